// File: rtl/dac_offset_tx.sv
// Restores the DAC mid-scale offset on a signed equalizer sample, clips it to the DAC code range
// and shifts it out as a 16-bit SPI frame (sync_n low, sclk idles high, DAC samples on sclk fall).
module dac_offset_tx #(
  parameter int ancho    = 13,
  parameter int anchodac = 12,
  parameter int OFFSET   = 2048,
  parameter int DIV      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [ancho-1:0] X,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    sat,
  output logic                    overrun,
  output logic                    sync_n,
  output logic                    sclk,
  output logic                    sdata
);

  localparam int SW = ancho + 2;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic signed [SW-1:0] CODE_MAX = SW'((2 ** anchodac) - 1);
  localparam logic signed [SW-1:0] OFFS     = SW'(OFFSET);
  localparam logic [CW-1:0]        HALF_TC  = CW'(DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_END   = 2'd2
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        half_cnt_q;
  logic [3:0]           bit_cnt_q;
  logic [15:0]          shift_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 sat_q;
  logic                 overrun_q;
  logic                 sync_n_q;
  logic                 sclk_q;

  logic signed [SW-1:0] sum_d;
  logic [anchodac-1:0]  code_d;
  logic                 sat_d;
  logic [15:0]          frame_d;

  // Two guard bits keep X + OFFSET exact before clipping.
  assign sum_d = $signed({{2{X[ancho-1]}}, X}) + OFFS;

  always_comb begin
    code_d = sum_d[anchodac-1:0];
    sat_d  = 1'b0;
    if (sum_d < 0) begin
      code_d = '0;
      sat_d  = 1'b1;
    end else if (sum_d > CODE_MAX) begin
      code_d = '1;
      sat_d  = 1'b1;
    end
  end

  assign frame_d = 16'(code_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      half_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sat_q      <= 1'b0;
      overrun_q  <= 1'b0;
      sync_n_q   <= 1'b1;
      sclk_q     <= 1'b1;
    end else begin
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          sync_n_q <= 1'b1;
          sclk_q   <= 1'b1;
          busy_q   <= 1'b0;
          if (start) begin
            state_q    <= ST_SHIFT;
            shift_q    <= frame_d;
            sat_q      <= sat_d;
            sync_n_q   <= 1'b0;
            busy_q     <= 1'b1;
            half_cnt_q <= '0;
            bit_cnt_q  <= '0;
          end
        end
        ST_SHIFT: begin
          if (start) overrun_q <= 1'b1;
          if (half_cnt_q == HALF_TC) begin
            half_cnt_q <= '0;
            sclk_q     <= ~sclk_q;
            // Shift on the rising sclk so data is stable across the DAC's falling-edge sample.
            if (!sclk_q) begin
              shift_q   <= {shift_q[14:0], 1'b0};
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd15) begin
                state_q  <= ST_END;
                sync_n_q <= 1'b1;
              end
            end
          end else begin
            half_cnt_q <= half_cnt_q + CW'(1);
          end
        end
        ST_END: begin
          if (start) overrun_q <= 1'b1;
          if (half_cnt_q == HALF_TC) begin
            half_cnt_q <= '0;
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            half_cnt_q <= half_cnt_q + CW'(1);
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          sync_n_q <= 1'b1;
          sclk_q   <= 1'b1;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  // The shift register is empty outside a frame, so its MSB doubles as the idle-low sdata.
  assign sdata   = shift_q[15];
  assign busy    = busy_q;
  assign done    = done_q;
  assign sat     = sat_q;
  assign overrun = overrun_q;
  assign sync_n  = sync_n_q;
  assign sclk    = sclk_q;

endmodule

// File: tb/tb_dac_offset_tx.sv
// Directed bench for dac_offset_tx: one DIV=2 instance and one DIV=1 instance sharing stimulus,
// with the serial frame captured on sclk falling edges as the DAC would see it.
module tb_dac_offset_tx;

  logic               clk;
  logic               reset;
  logic signed [12:0] X;
  logic               start;
  logic               sel;

  logic busy0, done0, sat0, overrun0, sync_n0, sclk0, sdata0;
  logic busy1, done1, sat1, overrun1, sync_n1, sclk1, sdata1;
  logic m_busy, m_done, m_sat, m_overrun, m_sync_n, m_sclk, m_sdata;

  int passed;
  int total;

  dac_offset_tx #(.ancho(13), .anchodac(12), .OFFSET(2048), .DIV(2)) dut0 (
    .clk(clk), .reset(reset), .X(X), .start(start),
    .busy(busy0), .done(done0), .sat(sat0), .overrun(overrun0),
    .sync_n(sync_n0), .sclk(sclk0), .sdata(sdata0)
  );

  dac_offset_tx #(.ancho(13), .anchodac(12), .OFFSET(2048), .DIV(1)) dut1 (
    .clk(clk), .reset(reset), .X(X), .start(start),
    .busy(busy1), .done(done1), .sat(sat1), .overrun(overrun1),
    .sync_n(sync_n1), .sclk(sclk1), .sdata(sdata1)
  );

  assign m_busy    = sel ? busy1    : busy0;
  assign m_done    = sel ? done1    : done0;
  assign m_sat     = sel ? sat1     : sat0;
  assign m_overrun = sel ? overrun1 : overrun0;
  assign m_sync_n  = sel ? sync_n1  : sync_n0;
  assign m_sclk    = sel ? sclk1    : sclk0;
  assign m_sdata   = sel ? sdata1   : sdata0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts a frame for x and watches the selected DUT for 'window' cycles; optionally pulses
  // start again after sample ovr_at to provoke an overrun.
  task automatic send_frame(input logic signed [12:0] x, input int window, input int ovr_at,
                            output logic [15:0] frame, output int busy_cnt, output int falls,
                            output int dones, output int ovrs);
    logic prev;
    @(posedge clk); #1;
    X = x;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    frame = '0; busy_cnt = 0; falls = 0; dones = 0; ovrs = 0; prev = 1'b1;
    for (int c = 0; c < window; c++) begin
      @(negedge clk);
      if (m_busy) busy_cnt++;
      if (prev && !m_sclk) begin
        frame = {frame[14:0], m_sdata};
        falls++;
      end
      prev = m_sclk;
      if (m_done) dones++;
      if (m_overrun) ovrs++;
      start = (c == ovr_at);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; X = '0; sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (sync_n0 !== 1'b1) $display("FAIL rst_sync_n got %b want 1", sync_n0); else passed++;
    total++; if (sclk0 !== 1'b1) $display("FAIL rst_sclk got %b want 1", sclk0); else passed++;
    total++; if (sdata0 !== 1'b0) $display("FAIL rst_sdata got %b want 0", sdata0); else passed++;
    total++; if (busy0 !== 1'b0) $display("FAIL rst_busy got %b want 0", busy0); else passed++;
    total++; if (done0 !== 1'b0) $display("FAIL rst_done got %b want 0", done0); else passed++;
    total++; if (sat0 !== 1'b0) $display("FAIL rst_sat got %b want 0", sat0); else passed++;
    total++; if (overrun0 !== 1'b0) $display("FAIL rst_overrun got %b want 0", overrun0); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_single;
    logic [15:0] f; int b, fl, d, o;
    send_frame(13'sd0, 80, -1, f, b, fl, d, o);
    total++; if (f !== 16'h0800) $display("FAIL single_frame got %h want 0800", f); else passed++;
    total++; if (m_sat !== 1'b0) $display("FAIL single_sat got %b want 0", m_sat); else passed++;
    total++; if (b != 66) $display("FAIL single_busy got %0d want 66", b); else passed++;
    total++; if (fl != 16) $display("FAIL single_falls got %0d want 16", fl); else passed++;
    total++; if (d != 1) $display("FAIL single_done got %0d want 1", d); else passed++;
  endtask

  task automatic test_saturation;
    logic signed [12:0] xs [5];
    logic [15:0]        fe [5];
    logic               se [5];
    logic [15:0] f; int b, fl, d, o;
    xs[0] = -13'sd4096; fe[0] = 16'h0000; se[0] = 1'b1;
    xs[1] =  13'sd4095; fe[1] = 16'h0FFF; se[1] = 1'b1;
    xs[2] =  13'sd2047; fe[2] = 16'h0FFF; se[2] = 1'b0;
    xs[3] = -13'sd2048; fe[3] = 16'h0000; se[3] = 1'b0;
    xs[4] = -13'sd1;    fe[4] = 16'h07FF; se[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_frame(xs[i], 72, -1, f, b, fl, d, o);
      total++;
      if (f !== fe[i]) $display("FAIL sat_frame[%0d] got %h want %h", i, f, fe[i]); else passed++;
      total++;
      if (m_sat !== se[i]) $display("FAIL sat_flag[%0d] got %b want %b", i, m_sat, se[i]); else passed++;
    end
  endtask

  task automatic test_overrun;
    logic [15:0] f; int b, fl, d, o;
    send_frame(13'sd100, 100, 20, f, b, fl, d, o);
    total++; if (o != 1) $display("FAIL ovr_pulses got %0d want 1", o); else passed++;
    total++; if (f !== 16'h0864) $display("FAIL ovr_frame got %h want 0864", f); else passed++;
    total++; if (b != 66) $display("FAIL ovr_busy got %0d want 66", b); else passed++;
    total++; if (d != 1) $display("FAIL ovr_done got %0d want 1", d); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] cap; int falls, dones, gap; logic low_seen, gap_done, prev;
    @(posedge clk); #1;
    X = 13'sd5;
    start = 1'b1;
    cap = '0; falls = 0; dones = 0; gap = 0; low_seen = 1'b0; gap_done = 1'b0; prev = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (prev && !m_sclk) begin
        cap = {cap[30:0], m_sdata};
        falls++;
      end
      prev = m_sclk;
      if (!m_sync_n) begin
        low_seen = 1'b1;
        if (gap > 0) gap_done = 1'b1;
      end else if (low_seen && !gap_done) begin
        gap++;
      end
      if (m_done) begin
        dones++;
        if (dones == 1) X = -13'sd5;
        else start = 1'b0;
      end
    end
    start = 1'b0;
    total++; if (cap[31:16] !== 16'h0805) $display("FAIL b2b_frame0 got %h want 0805", cap[31:16]); else passed++;
    total++; if (cap[15:0] !== 16'h07FB) $display("FAIL b2b_frame1 got %h want 07fb", cap[15:0]); else passed++;
    total++; if (falls != 32) $display("FAIL b2b_falls got %0d want 32", falls); else passed++;
    total++; if (gap != 3) $display("FAIL b2b_gap got %0d want 3", gap); else passed++;
    total++; if (dones != 2) $display("FAIL b2b_done got %0d want 2", dones); else passed++;
  endtask

  task automatic test_reset_abort;
    logic [15:0] f; int b, fl, d, o, falls; logic prev, hit;
    @(posedge clk); #1;
    X = 13'sd200;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    falls = 0; prev = 1'b1; hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      if (prev && !m_sclk) falls++;
      prev = m_sclk;
      if (falls == 7) hit = 1'b1;
    end
    total++; if (!hit) $display("FAIL abort_reach got %0d falls want 7", falls); else passed++;
    reset = 1'b1;
    @(negedge clk);
    total++; if (m_sync_n !== 1'b1) $display("FAIL abort_sync_n got %b want 1", m_sync_n); else passed++;
    total++; if (m_sclk !== 1'b1) $display("FAIL abort_sclk got %b want 1", m_sclk); else passed++;
    total++; if (m_busy !== 1'b0) $display("FAIL abort_busy got %b want 0", m_busy); else passed++;
    total++; if (m_done !== 1'b0) $display("FAIL abort_done got %b want 0", m_done); else passed++;
    reset = 1'b0;
    send_frame(13'sd1, 80, -1, f, b, fl, d, o);
    total++; if (f !== 16'h0801) $display("FAIL abort_next_frame got %h want 0801", f); else passed++;
  endtask

  task automatic test_div1;
    logic [15:0] f; int b, fl, d, o;
    sel = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    send_frame(13'sd300, 50, -1, f, b, fl, d, o);
    total++; if (f !== 16'h092C) $display("FAIL div1_frame got %h want 092c", f); else passed++;
    total++; if (fl != 16) $display("FAIL div1_falls got %0d want 16", fl); else passed++;
    total++; if (b != 33) $display("FAIL div1_busy got %0d want 33", b); else passed++;
    total++; if (d != 1) $display("FAIL div1_done got %0d want 1", d); else passed++;
    sel = 1'b0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_single();
    test_saturation();
    test_overrun();
    test_back_to_back();
    test_reset_abort();
    test_div1();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dac_offset_tx.md
# dac_offset_tx

Output-side counterpart of the input offset-removal stage in the equalizer datapath. Takes one signed, offset-free equalizer sample, adds the DAC mid-scale offset back, saturates it to the unsigned DAC code range, and shifts it out as a 16-bit SPI frame to a 12-bit serial DAC (DAC121S101 / PmodDA2 style). It sits between the equalizer summation output and the board DAC pins.

## Interface
Parameters:
- ancho, 13: width of signed input sample X.
- anchodac, 12: DAC code width; must satisfy anchodac ≤ ancho.
- OFFSET, 2048: unsigned offset added back (0 … 2^anchodac−1).
- DIV, 2: clk cycles per SCLK half-period (≥1).

Ports:
- clk  input  1  system clock; every register updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- X  input  ancho  signed two's-complement sample; sampled only when a start is accepted.
- start  input  1  request to convert and send X.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse at the end of a frame.
- sat  output  1  registered flag: the last accepted sample was clipped.
- overrun  output  1  one-cycle pulse when start arrives while busy.
- sync_n  output  1  DAC frame sync, active low.
- sclk  output  1  DAC serial clock; idles high.
- sdata  output  1  DAC serial data, MSB first.

## Operation
- Arithmetic, in ancho+2 bits signed: S = sign-extended X + OFFSET.
  - S < 0: code = 0, sat = 1.
  - S > 2^anchodac−1: code = 2^anchodac−1, sat = 1.
  - Otherwise: code = S[anchodac−1:0], sat = 0.
- Frame: 16 bits = {(16−anchodac) zero bits, code}, sent MSB first.
- FSM states:
  - IDLE: sync_n=1, sclk=1, busy=0. If start=1, latch code and sat into the shift register, then go to SHIFT.
  - SHIFT: sync_n=0. A half-period counter runs 0…DIV−1 and toggles sclk at each terminal count. sdata = shift_reg[15].
    - The shift register moves left by one on each sclk low→high transition, so sdata changes only while sclk rises. The DAC samples on the falling edge.
    - After 16 full SCLK periods (32·DIV cycles) go to END.
  - END: sync_n=1, sclk=1, sdata=0 for DIV cycles, then go to IDLE.
- done is asserted for one cycle, the first IDLE cycle after END.
- start in any state other than IDLE: ignored, and overrun pulses for that cycle. The frame in progress is unaffected.
- start in the done cycle is accepted, because that cycle is already IDLE. This gives back-to-back frames with no gap beyond END.
- sat holds its value until the next accepted start.
- reset in any state: on the next edge the FSM returns to IDLE and sync_n=1. This aborts the partial frame (the DAC discards frames shorter than 16 bits).

## Timing
- Reset values: sync_n=1, sclk=1, sdata=0, busy=0, done=0, sat=0, overrun=0; counters and shift register 0.
- start high in the cycle before edge k: from k, busy=1, sync_n=0, sclk=1, sdata=frame[15].
- Each bit i is held on sdata for 2·DIV cycles (sclk high DIV, then low DIV). Exactly 16 sclk falling edges occur per frame.
- busy stays high for 33·DIV cycles. The done pulse coincides with busy=0. With DIV=2, busy is high for 66 cycles.
- Start-to-first-falling-SCLK latency: DIV+1 cycles.
- Maximum frame rate: one frame per 33·DIV+1 cycles.

## Test plan
- X=0, OFFSET=2048, DIV=2, single start → serial capture on sclk falling edges = 0x0800; sat=0; busy high 66 cycles; one done pulse.
- Saturation sweep:
  - X=−4096 → 0x0000, sat=1.
  - X=4095 → 0x0FFF, sat=1.
  - X=2047 → 0x0FFF, sat=0.
  - X=−2048 → 0x0000, sat=0.
  - X=−1 → 0x07FF, sat=0.
- start pulsed at cycle 20 of a frame carrying X=100 → overrun pulses once; captured frame = 0x0864; no second frame follows.
- start held high continuously, X alternating 5 / −5 → frames 0x0805 and 0x07FB back-to-back; each gap has sync_n=1 for exactly DIV cycles plus the done cycle.
- reset asserted after the 7th sclk falling edge → next edge gives sync_n=1, sclk=1, busy=0, done=0. A later start with X=1 → full frame 0x0801.
- DIV=1, X=300 → frame 0x092C; 16 falling edges; busy high 33 cycles.
